// File: rtl/aes_key_expander.sv
// aes_key_expander: sequential AES key schedule for AES-128/192/256.
// Loads the cipher key on an accepted start and then generates one 32-bit
// schedule word per clock into a 60-word store. Completed 128-bit round keys
// can be read by index while later keys are still being generated.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   start        - load key_in and begin expansion (accepted in IDLE/DONE)
//   key_len      - 00=128, 01=192, 10=256, 11=illegal (err_len pulse)
//   key_in       - cipher key, bit 1 = MSB, left-aligned
//   rd_idx       - round key index to read (0..14)
//   rd_key       - registered round key rd_idx, 0 if not yet available
//   rk_avail     - number of complete round keys in the store
//   num_rounds   - Nr of the latched key length (0 after reset)
//   busy         - expansion in progress
//   done         - all Nr+1 round keys complete
//   err_len      - one-cycle pulse when a start with key_len=11 is rejected

// Byte substitution: GF(2^8) inverse (as x^254) followed by the affine map.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] r;
    r = '0;
    p = x;
    for (int unsigned b = 0; b < 8; b++) begin
      if (y[b]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0 as required.
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int unsigned SBOX_INST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [1:256] key_in,
  input  logic [3:0]   rd_idx,
  output logic [1:128] rd_key,
  output logic [3:0]   rk_avail,
  output logic [3:0]   num_rounds,
  output logic         busy,
  output logic         done,
  output logic         err_len
);
  if (SBOX_INST != 4) begin : g_bad_sbox_inst
    $error("aes_key_expander: SBOX_INST must be 4");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

  state_t      state;
  logic [1:0]  klen;
  logic [5:0]  i;
  logic [2:0]  pos;       // i mod Nk, tracked incrementally to avoid a divider
  logic [7:0]  rcon;
  logic [31:0] w [0:59];

  logic [255:0] key_v;
  logic [3:0]   nk_cur, nk_new, nr_new;
  logic [5:0]   last_idx;
  logic         accept, reject;
  logic [31:0]  prev, sub_in, sub_out, temp, new_word;

  assign key_v  = key_in;
  assign accept = start && (key_len != 2'b11) && (state != ST_EXPAND);
  assign reject = start && (key_len == 2'b11) && (state != ST_EXPAND);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    nk_cur   = 4'd8;
    last_idx = 6'd59;
    case (klen)
      2'b00:   begin nk_cur = 4'd4; last_idx = 6'd43; end
      2'b01:   begin nk_cur = 4'd6; last_idx = 6'd51; end
      default: begin nk_cur = 4'd8; last_idx = 6'd59; end
    endcase
  end

  always_comb begin
    nk_new = 4'd8;
    nr_new = 4'd14;
    case (key_len)
      2'b00:   begin nk_new = 4'd4; nr_new = 4'd10; end
      2'b01:   begin nk_new = 4'd6; nr_new = 4'd12; end
      default: begin nk_new = 4'd8; nr_new = 4'd14; end
    endcase
  end

  assign prev   = w[i - 6'd1];
  assign sub_in = (pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .s (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = prev;
    if (pos == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if ((klen == 2'b10) && (pos == 3'd4))
      temp = sub_out;
    new_word = w[i - {2'b00, nk_cur}] ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      klen       <= '0;
      i          <= '0;
      pos        <= '0;
      rcon       <= 8'h01;
      rk_avail   <= '0;
      num_rounds <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      err_len <= reject;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state      <= ST_EXPAND;
            klen       <= key_len;
            i          <= {2'b00, nk_new};
            pos        <= '0;
            rcon       <= 8'h01;
            rk_avail   <= (key_len == 2'b10) ? 4'd2 : 4'd1;
            num_rounds <= nr_new;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ST_EXPAND: begin
          i   <= i + 6'd1;
          pos <= ({1'b0, pos} == nk_cur - 4'd1) ? 3'd0 : pos + 3'd1;
          if (pos == 3'd0) rcon <= xtime(rcon);
          if (i[1:0] == 2'b11) rk_avail <= i[5:2] + 4'd1;
          if (i == last_idx) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Key store is deliberately not reset; rk_avail gates every read of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      w[0] <= key_v[255:224];
      w[1] <= key_v[223:192];
      w[2] <= key_v[191:160];
      w[3] <= key_v[159:128];
      if (key_len != 2'b00) begin
        w[4] <= key_v[127:96];
        w[5] <= key_v[95:64];
      end
      if (key_len == 2'b10) begin
        w[6] <= key_v[63:32];
        w[7] <= key_v[31:0];
      end
    end else if (state == ST_EXPAND) begin
      w[i] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_key <= '0;
    else if (rd_idx < rk_avail)
      rd_key <= {w[{rd_idx, 2'b00}], w[{rd_idx, 2'b01}],
                 w[{rd_idx, 2'b10}], w[{rd_idx, 2'b11}]};
    else
      rd_key <= '0;
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed testbench for aes_key_expander using FIPS-197 key expansion vectors.
module tb_aes_key_expander;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'b00;
  logic [1:256] key_in = '0;
  logic [3:0]   rd_idx = 4'd0;
  logic [1:128] rd_key;
  logic [3:0]   rk_avail;
  logic [3:0]   num_rounds;
  logic         busy;
  logic         done;
  logic         err_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_key_expander #(.SBOX_INST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_len    (key_len),
    .key_in     (key_in),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rk_avail   (rk_avail),
    .num_rounds (num_rounds),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len)
  );

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL reset_rd_key: got %h want 0", rd_key); end
    checks++; if (rk_avail !== 4'd0) begin errors++; $display("FAIL reset_rk_avail: got %0d want 0", rk_avail); end
    checks++; if (num_rounds !== 4'd0) begin errors++; $display("FAIL reset_num_rounds: got %0d want 0", num_rounds); end
    checks++; if ({busy, done, err_len} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, err_len}); end
    step; step;
    @(negedge clk);
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_illegal_len;
    key_len = 2'b11; key_in = K128; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL illegal_err_pulse: got %b want 1", err_len); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: got %b want 0", busy); end
    checks++; if (num_rounds !== 4'd0) begin errors++; $display("FAIL illegal_num_rounds: got %0d want 0", num_rounds); end
    checks++; if (rk_avail !== 4'd0) begin errors++; $display("FAIL illegal_rk_avail: got %0d want 0", rk_avail); end
    step;
    checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL illegal_err_single: got %b want 0", err_len); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL illegal_state_idle: got %b want 00", {busy, done}); end
  endtask

  // Polls the newest round key every cycle while AES-128 expansion runs.
  task automatic test_aes128_early;
    logic [127:0] exp_rd;
    logic [3:0]   ea;
    exp_rd = '0;
    key_len = 2'b00; key_in = K128; rd_idx = 4'd0; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (num_rounds !== 4'd10) begin errors++; $display("FAIL a128_num_rounds: got %0d want 10", num_rounds); end
    for (int m = 0; m <= 40; m++) begin
      ea = 4'(1 + m / 4);
      checks++; if (rk_avail !== ea) begin errors++; $display("FAIL a128_rk_avail m=%0d: got %0d want %0d", m, rk_avail, ea); end
      checks++; if (busy !== (m < 40)) begin errors++; $display("FAIL a128_busy m=%0d: got %b want %b", m, busy, m < 40); end
      checks++; if (done !== (m == 40)) begin errors++; $display("FAIL a128_done m=%0d: got %b want %b", m, done, m == 40); end
      if (m > 0) begin
        checks++; if (rd_key !== exp_rd) begin errors++; $display("FAIL a128_early_read m=%0d idx=%0d: got %h want %h", m, rd_idx, rd_key, exp_rd); end
      end
      if (m == 40) break;
      if (m % 2 == 1) begin
        rd_idx = ea;
        exp_rd = '0;
      end else begin
        rd_idx = ea - 4'd1;
        exp_rd = RK128[ea - 4'd1];
      end
      step;
    end
    rd_idx = 4'd1; step;
    checks++; if (rd_key !== RK128[1]) begin errors++; $display("FAIL a128_rk1: got %h want %h", rd_key, RK128[1]); end
    rd_idx = 4'd10; step;
    checks++; if (rd_key !== RK128[10]) begin errors++; $display("FAIL a128_rk10: got %h want %h", rd_key, RK128[10]); end
    rd_idx = 4'd11; step;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL a128_rk11_zero: got %h want 0", rd_key); end
    rd_idx = 4'd15; step;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL a128_rk15_zero: got %h want 0", rd_key); end
  endtask

  // Restart from DONE with AES-192; stray starts mid-expansion must be ignored.
  task automatic test_restart_192;
    key_len = 2'b01; key_in = K192; rd_idx = 4'd10; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL r192_accept_flags: got %b want 01", {done, busy}); end
    checks++; if (rk_avail !== 4'd1) begin errors++; $display("FAIL r192_rk_avail: got %0d want 1", rk_avail); end
    checks++; if (num_rounds !== 4'd12) begin errors++; $display("FAIL r192_num_rounds: got %0d want 12", num_rounds); end
    for (int m = 1; m <= 46; m++) begin
      if (m == 10) begin start = 1'b1; key_len = 2'b10; key_in = K256; end
      if (m == 12) begin start = 1'b1; key_len = 2'b11; end
      step;
      start = 1'b0;
      if (m == 1) begin
        checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL r192_old_key_zero: got %h want 0", rd_key); end
      end
      if (m == 10 || m == 12) begin
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL r192_no_err_in_expand m=%0d: got %b want 0", m, err_len); end
      end
      checks++; if (done !== (m == 46)) begin errors++; $display("FAIL r192_done m=%0d: got %b want %b", m, done, m == 46); end
      checks++; if (busy !== (m < 46)) begin errors++; $display("FAIL r192_busy m=%0d: got %b want %b", m, busy, m < 46); end
    end
    rd_idx = 4'd12; step;
    checks++; if (rd_key !== 128'he98ba06f448c773c8ecc720401002202) begin errors++; $display("FAIL r192_rk12: got %h want e98ba06f448c773c8ecc720401002202", rd_key); end
    rd_idx = 4'd13; step;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL r192_rk13_zero: got %h want 0", rd_key); end
    rd_idx = 4'd0; step;
    checks++; if (rd_key !== 128'h8e73b0f7da0e6452c810f32b809079e5) begin errors++; $display("FAIL r192_rk0: got %h want 8e73b0f7da0e6452c810f32b809079e5", rd_key); end
    checks++; if (num_rounds !== 4'd12) begin errors++; $display("FAIL r192_num_rounds_end: got %0d want 12", num_rounds); end
  endtask

  task automatic test_aes256;
    key_len = 2'b10; key_in = K256; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (rk_avail !== 4'd2) begin errors++; $display("FAIL a256_rk_avail: got %0d want 2", rk_avail); end
    checks++; if (num_rounds !== 4'd14) begin errors++; $display("FAIL a256_num_rounds: got %0d want 14", num_rounds); end
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL a256_accept_flags: got %b want 01", {done, busy}); end
    for (int m = 1; m <= 52; m++) begin
      step;
      checks++; if (done !== (m == 52)) begin errors++; $display("FAIL a256_done m=%0d: got %b want %b", m, done, m == 52); end
    end
    rd_idx = 4'd14; step;
    checks++; if (rd_key !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL a256_rk14: got %h want fe4890d1e6188d0b046df344706c631e", rd_key); end
    rd_idx = 4'd1; step;
    checks++; if (rd_key !== 128'h1f352c073b6108d72d9810a30914dff4) begin errors++; $display("FAIL a256_rk1: got %h want 1f352c073b6108d72d9810a30914dff4", rd_key); end
    rd_idx = 4'd15; step;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL a256_rk15_zero: got %h want 0", rd_key); end
  endtask

  task automatic test_reset_mid;
    key_len = 2'b10; key_in = K256; rd_idx = 4'd0; start = 1'b1;
    step;
    start = 1'b0;
    for (int m = 1; m <= 20; m++) step;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL rmid_rd_key: got %h want 0", rd_key); end
    checks++; if (rk_avail !== 4'd0) begin errors++; $display("FAIL rmid_rk_avail: got %0d want 0", rk_avail); end
    checks++; if (num_rounds !== 4'd0) begin errors++; $display("FAIL rmid_num_rounds: got %0d want 0", num_rounds); end
    checks++; if ({busy, done, err_len} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b want 000", {busy, done, err_len}); end
    step;
    @(negedge clk);
    rst_n = 1'b1;
    key_len = 2'b00; key_in = K128; start = 1'b1;
    step;
    start = 1'b0;
    checks++; if (rk_avail !== 4'd1) begin errors++; $display("FAIL rmid_a128_rk_avail: got %0d want 1", rk_avail); end
    checks++; if (num_rounds !== 4'd10) begin errors++; $display("FAIL rmid_a128_num_rounds: got %0d want 10", num_rounds); end
    for (int m = 1; m <= 40; m++) begin
      step;
      checks++; if (done !== (m == 40)) begin errors++; $display("FAIL rmid_a128_done m=%0d: got %b want %b", m, done, m == 40); end
    end
    rd_idx = 4'd1; step;
    checks++; if (rd_key !== RK128[1]) begin errors++; $display("FAIL rmid_a128_rk1: got %h want %h", rd_key, RK128[1]); end
    rd_idx = 4'd5; step;
    checks++; if (rd_key !== RK128[5]) begin errors++; $display("FAIL rmid_a128_rk5: got %h want %h", rd_key, RK128[5]); end
    rd_idx = 4'd10; step;
    checks++; if (rd_key !== RK128[10]) begin errors++; $display("FAIL rmid_a128_rk10: got %h want %h", rd_key, RK128[10]); end
    rd_idx = 4'd14; step;
    checks++; if (rd_key !== 128'h0) begin errors++; $display("FAIL rmid_a128_rk14_zero: got %h want 0", rd_key); end
  endtask

  initial begin
    #3;
    test_reset;
    test_illegal_len;
    test_aes128_early;
    test_restart_192;
    test_aes256;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
